// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one downstream memory port between instruction fetch and
// load/store. One transaction in flight at a time; round-robin on simultaneous requests.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned INST_W = 32
) (
   input  logic              clock,
   input  logic              reset,

   // Instruction fetch
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic [1:0]        if_size,
   input  logic              if_req,
   output logic              if_ready,
   output logic [INST_W-1:0] if_data_read,
   output logic [1:0]        if_resp,

   // Load/store
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_size,
   input  logic              mem_req,
   input  logic [DATA_W-1:0] mem_data_write,
   output logic              mem_ready,
   output logic [DATA_W-1:0] mem_data_read,
   output logic [1:0]        mem_resp,

   // Downstream bridge
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [1:0]        out_size,
   output logic              out_req,
   output logic [DATA_W-1:0] out_data_write,
   input  logic [DATA_W-1:0] out_data_read,
   input  logic [1:0]        out_resp,

   output logic              grant_if,
   output logic              grant_mem
);

   typedef enum logic [1:0] {StIdle, StGntIf, StGntMem} state_e;

   state_e              state_q, state_d;
   logic                last_mem_q, last_mem_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [1:0]          out_size_q, out_size_d;
   logic                out_req_q, out_req_d;
   logic [DATA_W-1:0]   out_data_write_q, out_data_write_d;
   logic                pick_if, pick_mem;

   // State register; last_mem resets high so fetch wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= StIdle;
         last_mem_q       <= 1'b1;
         out_addr_q       <= '0;
         out_size_q       <= '0;
         out_req_q        <= 1'b0;
         out_data_write_q <= '0;
      end else begin
         state_q          <= state_d;
         last_mem_q       <= last_mem_d;
         out_addr_q       <= out_addr_d;
         out_size_q       <= out_size_d;
         out_req_q        <= out_req_d;
         out_data_write_q <= out_data_write_d;
      end
   end

   assign pick_if  = if_valid  && (!mem_valid || last_mem_q);
   assign pick_mem = mem_valid && (!if_valid  || !last_mem_q);

   // Next state; the command registers only load on the idle-to-grant transition.
   always_comb begin
      state_d          = state_q;
      last_mem_d       = last_mem_q;
      out_addr_d       = out_addr_q;
      out_size_d       = out_size_q;
      out_req_d        = out_req_q;
      out_data_write_d = out_data_write_q;
      unique case (state_q)
         StIdle: begin
            if (pick_if) begin
               state_d          = StGntIf;
               out_addr_d       = if_addr;
               out_size_d       = if_size;
               out_req_d        = if_req;
               out_data_write_d = '0;
            end else if (pick_mem) begin
               state_d          = StGntMem;
               out_addr_d       = mem_addr;
               out_size_d       = mem_size;
               out_req_d        = mem_req;
               out_data_write_d = mem_data_write;
            end
         end
         StGntIf: begin
            if (out_ready) begin
               state_d    = StIdle;
               last_mem_d = 1'b0;
            end
         end
         StGntMem: begin
            if (out_ready) begin
               state_d    = StIdle;
               last_mem_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs; response routing is combinational in the completion cycle.
   always_comb begin
      out_valid     = 1'b0;
      grant_if      = 1'b0;
      grant_mem     = 1'b0;
      if_ready      = 1'b0;
      if_data_read  = '0;
      if_resp       = '0;
      mem_ready     = 1'b0;
      mem_data_read = '0;
      mem_resp      = '0;
      unique case (state_q)
         StGntIf: begin
            out_valid = 1'b1;
            grant_if  = 1'b1;
            if (out_ready) begin
               if_ready     = 1'b1;
               if_data_read = out_addr_q[2] ? out_data_read[INST_W +: INST_W]
                                            : out_data_read[0 +: INST_W];
               if_resp      = out_resp;
            end
         end
         StGntMem: begin
            out_valid = 1'b1;
            grant_mem = 1'b1;
            if (out_ready) begin
               mem_ready     = 1'b1;
               mem_data_read = out_data_read;
               mem_resp      = out_resp;
            end
         end
         default: ;
      endcase
   end

   assign out_addr       = out_addr_q;
   assign out_size       = out_size_q;
   assign out_req        = out_req_q;
   assign out_data_write = out_data_write_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single downstream memory/AXI-bridge port between the instruction-fetch interface (`if_*`) and the load/store interface (`mem_*`) of `cpu`. It accepts one transaction at a time, latches the winning requester's command, presents it downstream, and routes the response back only to the granted requester. It sits between `cpu` and the AXI read/write bridge.

## Interface
- `ADDR_W`, 64: address width of all ports.
- `DATA_W`, 64: data width of the `mem_*` and downstream ports.
- `INST_W`, 32: data width of the `if_*` read-data port.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `if_valid`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_size`  in  2  fetch size code.
- `if_req`  in  1  0 = read; always 0 for fetch.
- `if_ready`  out  1  one-cycle completion pulse to fetch.
- `if_data_read`  out  INST_W  fetched instruction, valid with `if_ready`.
- `if_resp`  out  2  response code, valid with `if_ready`.
- `mem_valid`, `mem_addr`, `mem_size`, `mem_req` (0 = read, 1 = write)  in  1/ADDR_W/2/1  data request.
- `mem_data_write`  in  DATA_W  store data.
- `mem_ready`  out  1  completion pulse to load/store.
- `mem_data_read`  out  DATA_W  load data, valid with `mem_ready`.
- `mem_resp`  out  2  response code, valid with `mem_ready`.
- `out_valid`  out  1  downstream request.
- `out_ready`  in  1  downstream completion pulse.
- `out_addr`, `out_size`, `out_req`, `out_data_write`  out  ADDR_W/2/1/DATA_W  latched command.
- `out_data_read`  in  DATA_W  downstream read data.
- `out_resp`  in  2  downstream response code.
- `grant_if`, `grant_mem`  out  1  one-hot current owner; both 0 when idle.

## Operation
- FSM states: IDLE, GNT_IF, GNT_MEM.
- IDLE: if exactly one of `if_valid` or `mem_valid` is high, grant that requester. If both are high, grant the requester not granted last (round-robin bit `last_mem`). Going to GNT_x latches addr, size, req, and write data (write data is 0 for IF) into the `out_*` registers.
- GNT_x: `out_valid` = 1 and the command registers are frozen. When `out_ready` = 1, pulse the granted requester's `*_ready`, return to IDLE, and set `last_mem` = (state == GNT_MEM).
- Response routing is combinational in the completion cycle. The non-granted requester's ready output is 0, and its data/resp outputs are 0.
- IF data select: `if_data_read` = `out_data_read[63:32]` when the latched `out_addr[2]` = 1, else `[31:0]`.
- Requests cannot be withdrawn. A requester that drops valid after being granted still has its transaction completed and receives its ready pulse.
- A requester's valid is sampled only in IDLE. The input fields of an ungranted requester are ignored.
- Reset values: state IDLE, `last_mem` = 1 (IF wins the first tie). All outputs are 0: `out_*`, `grant_*`, `*_ready`, `*_data_read`, `*_resp`.

## Timing
- Grant latency: valid seen in IDLE at cycle N, then `out_valid` = 1 and `grant_x` = 1 at N+1.
- Completion: `*_ready` is high in the same cycle as `out_ready`, for exactly one cycle. The state is IDLE at the next cycle.
- Back-to-back: a requester still valid in the IDLE cycle after completion may be re-granted, subject to round-robin. Minimum spacing between two downstream requests is one idle cycle.
- Simultaneous events:
  - `out_ready` while IDLE is ignored; nothing is pulsed.
  - A new valid arriving in the completion cycle is not granted until the following IDLE cycle.
- Reset mid-transaction: state goes to IDLE at the next edge. `out_valid`, `grant_*` and `*_ready` are 0 from that edge onward. Any in-flight response is dropped, because the downstream bridge shares the same reset.
- `out_*` command fields hold their last value in IDLE. Only `out_valid` qualifies them.

## Test plan
- Single fetch:
  - Stimulus: `if_valid`=1, `if_addr`=0x8000_0004; `out_ready` pulsed 3 cycles after grant with `out_data_read`=0x1111_2222_3333_4444.
  - Required: `out_valid` at N+1 with `out_addr`=0x8000_0004, `out_req`=0; `if_ready` for 1 cycle with `if_data_read`=0x1111_2222; `mem_ready` stays 0.
- Store:
  - Stimulus: `mem_valid`=1, `mem_req`=1, `mem_addr`=0x8000_1000, `mem_data_write`=0xDEAD_BEEF_0000_0001.
  - Required: downstream fields match exactly; `mem_ready` pulses with `out_ready`; `out_valid` falls the next cycle.
- Tie after reset:
  - Stimulus: both valid at cycle 1, held.
  - Required: IF granted first; MEM granted after IF completes plus 1 idle cycle; then IF again (alternation over 4 transactions).
- Withdrawal:
  - Stimulus: `mem_valid` dropped one cycle after grant.
  - Required: `out_valid` stays 1 until `out_ready`; `mem_ready` still pulses once.
- Reset mid-operation:
  - Stimulus: assert `reset` while in GNT_MEM with `out_ready`=0, then release with `if_valid`=1.
  - Required: all outputs 0 after the reset edge; IF granted 1 cycle after release.
- Spurious `out_ready` in IDLE:
  - Required: no `*_ready` pulse; no state change.
